// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: WB has priority, buffered MU results drain into
// idle port slots, with a pending-destination mask and a starvation stall request.
module rf_write_scheduler #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    input  logic                    wb_dual,
    input  logic                    wb_r15,
    input  logic [3:0]              wb_reg1,
    input  logic [3:0]              wb_reg2,
    input  logic [15:0]             wb_data1,
    input  logic [15:0]             wb_data2,
    input  logic                    mu_valid,
    output logic                    mu_ready,
    input  logic                    mu_dual,
    input  logic [3:0]              mu_reg1,
    input  logic [15:0]             mu_data1,
    input  logic [15:0]             mu_data2,
    output logic [1:0]              regWrite,
    output logic [3:0]              WriteReg1,
    output logic [3:0]              WriteReg2,
    output logic [15:0]             WriteDataReg1,
    output logic [15:0]             WriteDataReg2,
    output logic                    WriteR15,
    output logic [15:0]             pend_mask,
    output logic                    wb_stall_req,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(STARVE_LIMIT + 1);

    logic [3:0]    f_reg  [DEPTH];
    logic [15:0]   f_d1   [DEPTH];
    logic [15:0]   f_d2   [DEPTH];
    logic          f_dual [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [GW-1:0] age, age_nx;
    logic          tag1, tag2;

    logic          head_v, push, pop;
    logic [1:0]    n_rw;
    logic [3:0]    n_r1, n_r2;
    logic [15:0]   n_d1, n_d2;
    logic          n_r15, n_t1, n_t2;

    // mu_ready deliberately ignores a same-cycle pop
    assign mu_ready = fifo_count != CW'(DEPTH);
    assign push     = mu_valid & mu_ready;
    assign head_v   = fifo_count != '0;

    always_comb begin
        n_rw  = 2'b00;
        n_r1  = WriteReg1;
        n_r2  = WriteReg2;
        n_d1  = WriteDataReg1;
        n_d2  = WriteDataReg2;
        n_r15 = WriteR15;
        n_t1  = 1'b0;
        n_t2  = 1'b0;
        pop   = 1'b0;
        if (wb_valid && wb_dual) begin
            n_rw  = 2'b10;
            n_r1  = wb_reg1;
            n_d1  = wb_data1;
            n_r2  = wb_reg2;
            n_d2  = wb_data2;
            n_r15 = wb_r15;
        end else if (wb_valid) begin
            n_r1  = wb_reg1;
            n_d1  = wb_data1;
            n_r15 = 1'b0;
            // a head aimed at the same register waits so the MU value lands last
            if (head_v && !f_dual[rd_ptr] && f_reg[rd_ptr] != wb_reg1) begin
                n_rw = 2'b10;
                n_r2 = f_reg[rd_ptr];
                n_d2 = f_d1[rd_ptr];
                n_t2 = 1'b1;
                pop  = 1'b1;
            end else begin
                n_rw = 2'b01;
            end
        end else if (head_v) begin
            pop  = 1'b1;
            n_r1 = f_reg[rd_ptr];
            n_d1 = f_d1[rd_ptr];
            n_t1 = 1'b1;
            if (f_dual[rd_ptr]) begin
                n_rw  = 2'b10;
                n_r2  = 4'd15;
                n_d2  = f_d2[rd_ptr];
                n_r15 = 1'b1;
                n_t2  = 1'b1;
            end else begin
                n_rw  = 2'b01;
                n_r15 = 1'b0;
            end
        end
    end

    always_comb begin
        if (pop || !head_v)
            age_nx = '0;
        else if (age == GW'(STARVE_LIMIT))
            age_nx = age;
        else
            age_nx = age + GW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_reg[wr_ptr]  <= mu_reg1;
            f_d1[wr_ptr]   <= mu_data1;
            f_d2[wr_ptr]   <= mu_data2;
            f_dual[wr_ptr] <= mu_dual;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            age           <= '0;
            wb_stall_req  <= 1'b0;
            regWrite      <= 2'b00;
            WriteReg1     <= '0;
            WriteReg2     <= '0;
            WriteDataReg1 <= '0;
            WriteDataReg2 <= '0;
            WriteR15      <= 1'b0;
            tag1          <= 1'b0;
            tag2          <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            age           <= age_nx;
            wb_stall_req  <= age_nx >= GW'(STARVE_LIMIT);
            regWrite      <= n_rw;
            WriteReg1     <= n_r1;
            WriteReg2     <= n_r2;
            WriteDataReg1 <= n_d1;
            WriteDataReg2 <= n_d2;
            WriteR15      <= n_r15;
            tag1          <= n_t1;
            tag2          <= n_t2;
        end
    end

    // Destinations still owed by MU: buffered entries plus MU writes sitting on the ports
    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(fifo_count)) begin
                idx = rd_ptr + AW'(i);
                pend_mask[f_reg[idx]] = 1'b1;
                if (f_dual[idx]) pend_mask[15] = 1'b1;
            end
        end
        if (tag1) pend_mask[WriteReg1] = 1'b1;
        if (tag2) pend_mask[WriteR15 ? 4'd15 : WriteReg2] = 1'b1;
    end
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Randomized bench for rf_write_scheduler against a queue-based model of the issue rules.
module tb_rf_write_scheduler;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 0, wb_dual = 0, wb_r15 = 0;
    logic [3:0]  wb_reg1 = 0, wb_reg2 = 0;
    logic [15:0] wb_data1 = 0, wb_data2 = 0;
    logic        mu_valid = 0, mu_dual = 0;
    logic [3:0]  mu_reg1 = 0;
    logic [15:0] mu_data1 = 0, mu_data2 = 0;
    logic        mu_ready, WriteR15, wb_stall_req;
    logic [1:0]  regWrite;
    logic [3:0]  WriteReg1, WriteReg2;
    logic [15:0] WriteDataReg1, WriteDataReg2, pend_mask;
    logic [2:0]  fifo_count;

    rf_write_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_dual(wb_dual), .wb_r15(wb_r15),
        .wb_reg1(wb_reg1), .wb_reg2(wb_reg2), .wb_data1(wb_data1), .wb_data2(wb_data2),
        .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_dual(mu_dual), .mu_reg1(mu_reg1),
        .mu_data1(mu_data1), .mu_data2(mu_data2),
        .regWrite(regWrite), .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
        .WriteDataReg1(WriteDataReg1), .WriteDataReg2(WriteDataReg2), .WriteR15(WriteR15),
        .pend_mask(pend_mask), .wb_stall_req(wb_stall_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        dual;
    } ent_t;

    ent_t        q[$];
    logic [1:0]  e_rw;
    logic [3:0]  e_r1, e_r2;
    logic [15:0] e_d1, e_d2, e_pend;
    logic        e_r15, e_stall;
    int          e_age;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_rw = 0; e_r1 = 0; e_r2 = 0; e_d1 = 0; e_d2 = 0; e_r15 = 0;
        e_pend = 0; e_stall = 0; e_age = 0;
    endtask

    // Apply one clock edge of the issue rules to the model, using the current inputs
    task automatic model_step();
        int          cnt  = q.size();
        logic        hv   = cnt != 0;
        logic        push = mu_valid && cnt < DEPTH;
        logic        pop  = 0;
        logic [15:0] tg   = 0;
        ent_t        h;
        ent_t        n;
        if (hv) h = q[0];
        if (wb_valid && wb_dual) begin
            e_rw = 2; e_r1 = wb_reg1; e_d1 = wb_data1;
            e_r2 = wb_reg2; e_d2 = wb_data2; e_r15 = wb_r15;
        end else if (wb_valid) begin
            e_r1 = wb_reg1; e_d1 = wb_data1; e_r15 = 0;
            if (hv && !h.dual && h.r != wb_reg1) begin
                e_rw = 2; e_r2 = h.r; e_d2 = h.d1; pop = 1; tg[h.r] = 1;
            end else begin
                e_rw = 1;
            end
        end else if (hv) begin
            pop = 1; e_r1 = h.r; e_d1 = h.d1; tg[h.r] = 1;
            if (h.dual) begin
                e_rw = 2; e_d2 = h.d2; e_r15 = 1; tg[15] = 1;
            end else begin
                e_rw = 1; e_r15 = 0;
            end
        end else begin
            e_rw = 0;
        end
        if (pop || !hv) e_age = 0;
        else if (e_age < LIMIT) e_age++;
        e_stall = e_age >= LIMIT;
        if (pop) void'(q.pop_front());
        if (push) begin
            n.r = mu_reg1; n.d1 = mu_data1; n.d2 = mu_data2; n.dual = mu_dual;
            q.push_back(n);
        end
        e_pend = tg;
        foreach (q[i]) begin
            e_pend[q[i].r] = 1'b1;
            if (q[i].dual) e_pend[15] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("regWrite", regWrite, e_rw);
        if (e_rw != 0) begin
            chk("WriteReg1", WriteReg1, e_r1);
            chk("WriteDataReg1", WriteDataReg1, e_d1);
        end
        if (e_rw == 2) begin
            chk("WriteR15", WriteR15, e_r15);
            chk("WriteDataReg2", WriteDataReg2, e_d2);
            if (!e_r15) chk("WriteReg2", WriteReg2, e_r2);
        end
        chk("fifo_count", fifo_count, q.size());
        chk("mu_ready", mu_ready, q.size() != DEPTH);
        chk("pend_mask", pend_mask, e_pend);
        chk("wb_stall_req", wb_stall_req, e_stall);
    endtask

    // Percent probabilities; registers drawn from 0..7 to force destination collisions
    task automatic drive(input int p_wb, input int p_wdual, input int p_mu, input int p_mdual);
        wb_valid = $urandom_range(0, 99) < p_wb;
        wb_dual  = $urandom_range(0, 99) < p_wdual;
        wb_r15   = $urandom_range(0, 1);
        wb_reg1  = 4'($urandom_range(0, 7));
        wb_reg2  = 4'($urandom_range(0, 15));
        wb_data1 = 16'($urandom);
        wb_data2 = 16'($urandom);
        mu_valid = $urandom_range(0, 99) < p_mu;
        mu_dual  = $urandom_range(0, 99) < p_mdual;
        mu_reg1  = 4'($urandom_range(0, 7));
        mu_data1 = 16'($urandom);
        mu_data2 = 16'($urandom);
    endtask

    task automatic run(input int n, input int p_wb, input int p_wdual, input int p_mu, input int p_mdual);
        for (int k = 0; k < n; k++) begin
            drive(p_wb, p_wdual, p_mu, p_mdual);
            model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic reset_now();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        wb_valid = 0; mu_valid = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        run(300, 50, 50, 60, 30);
        // WB dual every cycle: FIFO fills, head starves, stall must rise
        run(14, 100, 100, 100, 50);
        chk("full_count", fifo_count, DEPTH);
        chk("starved", wb_stall_req, 1);
        // WB idle: head issues and the stall clears
        run(6, 0, 0, 0, 0);
        // refill to three entries then reset mid-stream
        run(3, 100, 100, 100, 0);
        chk("pre_reset_count", fifo_count, 3);
        reset_now();
        run(200, 20, 30, 80, 40);
        run(200, 80, 20, 70, 20);
        run(12, 100, 100, 100, 100);
        reset_now();
        run(100, 50, 50, 50, 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
